// File: rtl/conv_pkg.sv
// Shared pixel type and helpers for the convolution result datapath.
package conv_pkg;

  localparam int PIX_W = 8;

  typedef logic signed [PIX_W-1:0] pixel_t;

  // Clamp negative convolution results to zero.
  function automatic pixel_t relu(input pixel_t pix);
    return pix[PIX_W-1] ? pixel_t'(0) : pix;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the caller never pushes when full
// unless it also pops in the same cycle, and never pops when empty.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      r_wr_ptr;
  logic [IW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;

  assign w_wr_idx = r_wr_ptr[IW-1:0];
  assign w_rd_idx = r_rd_ptr[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + (IW+1)'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + (IW+1)'(1);
    end
  end

  // Storage needs no reset; the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (push) r_mem[w_wr_idx] <= wdata;
  end

  assign rdata = r_mem[w_rd_idx];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
  assign level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/conv_result_collector.sv
// Collects convolution results, tags them with a linear pixel address and buffers them.
// Optional ReLU on stored pixels is enabled by defining CONV_RELU_EN.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int IMG_W      = 26,
  parameter int IMG_H      = 26,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [PIX_W-1:0]       in_data,
  input  logic                          in_valid,
  output logic [PIX_W-1:0]              out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int ENT_W = PIX_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow;
  logic              r_frame_done;

  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  pixel_t            w_pix;
  logic [ENT_W-1:0]  w_head;
  logic [ADDR_W-1:0] w_head_addr;

`ifdef CONV_RELU_EN
  assign w_pix = relu(in_data);
`else
  assign w_pix = in_data;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign w_push_req  = enable && in_valid;
  assign w_pop       = !w_empty && out_ready;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_head_addr = w_head[ADDR_W-1:0];

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({w_pix, r_addr}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      r_frame_done <= w_pop && (w_head_addr == LAST_ADDR);
    end
  end

  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : w_head[ENT_W-1 -: PIX_W];
  assign out_addr   = w_empty ? '0 : w_head_addr;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector against a queue-based reference model.
module tb_conv_result_collector;

  localparam int FRAME = 26 * 26;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [9:0] out_addr;
  logic       out_valid;
  logic       frame_done;
  logic       overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         addr;
  } ent_t;

  ent_t m_q[$];
  int   m_addr = 0;
  bit   m_ovf = 1'b0;
  bit   m_fd = 1'b0;

  conv_result_collector dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xform(input logic [7:0] d);
`ifdef CONV_RELU_EN
    if ($signed(d) < 0) return 8'h00;
`endif
    return d;
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle past the edge.
  task automatic cycle(input bit en, input bit v, input logic [7:0] d, input bit rdy);
    bit   do_pop;
    bit   do_push;
    ent_t e;
    enable = en; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    do_pop  = (m_q.size() > 0) && rdy;
    do_push = en && v && ((m_q.size() < DEPTH) || do_pop);
    m_fd = 1'b0;
    if (do_pop) begin
      e = m_q.pop_front();
      m_fd = (e.addr == FRAME - 1);
    end
    if (en && v && !do_push) m_ovf = 1'b1;
    if (do_push) begin
      e.data = xform(d);
      e.addr = m_addr;
      m_q.push_back(e);
      m_addr = (m_addr + 1) % FRAME;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_addr = 0; m_ovf = 1'b0; m_fd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %0b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
  endtask

  task automatic test_single_push();
    do_reset();
    cycle(1, 1, 8'h05, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'h05) begin errors++; $display("FAIL single_data got %h want 05", out_data); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL single_addr got %0d want 0", out_addr); end
    cycle(0, 0, 8'h00, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_relu();
    logic [7:0] want;
`ifdef CONV_RELU_EN
    want = 8'h00;
`else
    want = 8'hF3;
`endif
    do_reset();
    cycle(1, 1, 8'hF3, 1);
    checks++; if (out_data !== want) begin errors++; $display("FAIL relu_neg got %h want %h", out_data, want); end
    cycle(1, 1, 8'h7F, 1);
    checks++; if (out_data !== 8'h7F) begin errors++; $display("FAIL relu_pos got %h want 7f", out_data); end
    cycle(0, 0, 8'h00, 1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'(i + 1), 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_addr !== 10'(i) || out_data !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_drain%0d got addr %0d data %h want addr %0d data %h", i, out_addr, out_data, i, 8'(i + 1));
      end
      cycle(0, 0, 8'h00, 1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", out_valid); end
    cycle(1, 1, 8'h11, 1);
    checks++; if (out_addr !== 10'd4) begin errors++; $display("FAIL ovf_next_addr got %0d want 4", out_addr); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_frame();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      cycle(1, 1, 8'($urandom), 1);
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 10'(i)) begin
        errors++; $display("FAIL frame_addr%0d got valid %0b addr %0d want 1 %0d", i, out_valid, out_addr, i);
      end
    end
    cycle(0, 0, 8'h00, 1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done got %0b want 1", frame_done); end
    if (frame_done === 1'b1) pulses++;
    cycle(1, 1, 8'h22, 1);
    if (frame_done === 1'b1) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", pulses); end
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL frame_wrap got %0d want 0", out_addr); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h40 + i), 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL pp_pre_level got %0d want 4", level); end
    cycle(1, 1, 8'h55, 1);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL pp_level got %0d want 4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %0b want 0", overflow); end
    checks++; if (out_addr !== 10'd1) begin errors++; $display("FAIL pp_head got %0d want 1", out_addr); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1, 1, 8'($urandom), (i < 96) ? 1'($urandom) : 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_nonempty got %0b want 1", out_valid); end
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_addr !== 10'd0 || level !== 3'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mr_outputs got v%0b d%h a%0d l%0d o%0b f%0b want all zero", out_valid, out_data, out_addr, level, overflow, frame_done);
    end
    cycle(1, 1, 8'h33, 1);
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL mr_next_addr got %0d want 0", out_addr); end
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom), ($urandom_range(0, 9) < 6));
      checks++;
      if (level !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_level%0d got %0d want %0d", i, level, m_q.size()); end
      checks++;
      if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid%0d got %0b want %0b", i, out_valid, m_q.size() != 0); end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf%0d got %0b want %0b", i, overflow, m_ovf); end
      checks++;
      if (frame_done !== m_fd) begin errors++; $display("FAIL rnd_fd%0d got %0b want %0b", i, frame_done, m_fd); end
      if (m_q.size() != 0) begin
        h = m_q[0];
        checks++;
        if (out_data !== h.data || out_addr !== 10'(h.addr)) begin
          errors++; $display("FAIL rnd_head%0d got %h@%0d want %h@%0d", i, out_data, out_addr, h.data, h.addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_relu();
    test_overflow();
    test_full_frame();
    test_push_pop_full();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Final stage of the Laplacian convolution datapath; sits directly downstream of the last adder stage. Accepts one 8-bit signed convolution result per `done` strobe, optionally applies ReLU, tags each result with its linear output-image address, and buffers it in a small FIFO. The buffer drains to the output image memory over a valid/ready write port. Flags end of frame and sticky overflow.

## Interface
Parameters:
- `IMG_W`, 26: output image width in pixels (28-pixel input, 3x3 kernel).
- `IMG_H`, 26: output image height in pixels.
- `ADDR_W`, 10: write-address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- `FIFO_DEPTH`, 4: buffer entries; power of two, >= 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: stage enable; when low, input is ignored.
- `in_data`  in  8: signed two's-complement result from the adder stage.
- `in_valid`  in  1: result strobe, driven by the adder stage `done`.
- `out_data`  out  8: pixel to write.
- `out_addr`  out  ADDR_W: linear pixel address, row*IMG_W+col.
- `out_valid`  out  1: write request.
- `out_ready`  in  1: memory accepts the write.
- `frame_done`  out  1: one-cycle pulse when the last pixel of a frame is written.
- `overflow`  out  1: sticky; a result was dropped.
- `level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** A push occurs when `enable && in_valid`. There is no backpressure toward the adder stage, which has no stall.
- **Pixel transform.** Each pushed result is transformed (see Configuration), then stored in the FIFO together with the current address counter value.
- **Address counter.** The counter is linear, starts at 0 after reset, and increments by 1 on each accepted push. At IMG_W*IMG_H-1 it wraps to 0. It uses no multiplier.
- **Push while full.** Push with FIFO full and no pop in the same cycle: the result is dropped, the address counter does not advance, and `overflow` sets. `overflow` stays high until `reset`.
- **Push and pop together.** Push and pop in the same cycle are legal at any level, including full; level is unchanged.
- **Pop.** A pop occurs when `out_valid && out_ready`.
- **Output hold.** `out_valid = (level != 0)`. `out_data` and `out_addr` show the FIFO head and hold stable while `out_valid && !out_ready`.
- **frame_done.** Asserted for exactly one cycle, the cycle after a pop whose address is IMG_W*IMG_H-1.
- **enable low.** Pushes are blocked, the FIFO continues draining, and the counters hold.
- **Reset.** `reset` in mid-frame empties the FIFO and zeroes the address counter and `overflow`. The next accepted result gets address 0.
- **FIFO pointers.** Read/write pointers are $clog2(FIFO_DEPTH) bits plus one wrap bit. Full is detected as equal indices with different wrap bits.

## Timing
- **Reset values:** `out_data`=0, `out_addr`=0, `out_valid`=0, `frame_done`=0, `overflow`=0, `level`=0.
- **Latency:** a push at edge N, into an empty FIFO, is visible on `out_data`/`out_addr` with `out_valid`=1 after edge N (1 cycle).
- **Throughput:** one push and one pop per cycle, sustained.
- **Registered outputs:** `level` and `overflow` update on the same edge as the push or pop that changes them.

## Configuration
- `CONV_RELU_EN` defined: a negative `in_data` (bit 7 set) is stored as 8'h00; non-negative values are stored unchanged (0..127).
- `CONV_RELU_EN` undefined: `in_data` is stored unchanged as two's complement.
- All other behaviour is identical in both builds.

## Structure
- **Package `conv_pkg`:** `PIX_W`=8, and the `pixel_t` typedef (signed [7:0]).
- **Sub-module `sync_fifo`:** holds the storage and pointers. It is parameterised by width (PIX_W+ADDR_W) and depth, and exposes `push`, `pop`, `full`, `empty` and `level`.
- **Top level:** the transform, address counter, overflow flag and frame_done logic live in `conv_result_collector`.

## Test plan
- **Reset and single push:** reset, then push `in_data`=8'h05 with `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=8'h05, `out_addr`=0; the following cycle `out_valid`=0.
- **ReLU:** push 8'hF3 (-13) -> `out_data`=8'h00 with `CONV_RELU_EN` defined, 8'hF3 without.
- **Backpressure and overflow:** hold `out_ready`=0 and push 5 results (depth 4) -> `level`=4, `overflow`=1, 5th result dropped. Then release `out_ready` -> addresses 0,1,2,3 drain in order; the next push gets address 4.
- **Full frame:** 676 consecutive pushes with `out_ready`=1 -> addresses 0..675 in order, `frame_done` pulses once after the pop of address 675, and the next push gets address 0.
- **Simultaneous push/pop at full:** with `level`=4, push and pop in the same cycle -> `level` stays 4 and `overflow` stays 0.
- **Mid-frame reset:** reset after 100 pushes with the FIFO non-empty -> all outputs return to reset values; the next push gets address 0.
